// File: rtl/apa102_pkg.sv
// Shared types and constants for the APA102 frame receiver.
// Field positions describe one 32-bit LED word as it appears on the wire.
package apa102_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    PIXEL = 1'b1
  } rx_state_e;

  localparam int START_ZERO_BITS = 32;
  localparam int WORD_BITS       = 32;
  localparam logic [2:0] HDR_ONES = 3'b111;

  localparam int HDR_MSB    = 31;
  localparam int HDR_LSB    = 29;
  localparam int BRIGHT_MSB = 28;
  localparam int BRIGHT_LSB = 24;
  localparam int B_MSB      = 23;
  localparam int B_LSB      = 16;
  localparam int G_MSB      = 15;
  localparam int G_LSB      = 8;
  localparam int R_MSB      = 7;
  localparam int R_LSB      = 0;

endpackage

// File: rtl/apa102_frame_rx_if.sv
// Decoded pixel stream and per-frame status leaving the APA102 receiver.
// The receiver drives the master side; consumers attach to the slave side.
interface apa102_frame_rx_if #(
  parameter int MATRIX_W = 8,
  parameter int MATRIX_H = 8
);
  localparam int NUM_LEDS = MATRIX_W * MATRIX_H;
  localparam int IDX_W    = $clog2(NUM_LEDS);
  localparam int X_W      = $clog2(MATRIX_W);
  localparam int Y_W      = $clog2(MATRIX_H);

  logic             pix_valid;
  logic [IDX_W-1:0] pix_index;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic [4:0]       pix_bright;
  logic [7:0]       pix_b;
  logic [7:0]       pix_g;
  logic [7:0]       pix_r;
  logic             frame_done;
  logic             frame_err;
  logic [7:0]       frame_count;
  logic             busy;

  modport master (
    output pix_valid, pix_index, pix_x, pix_y, pix_bright, pix_b, pix_g, pix_r,
    output frame_done, frame_err, frame_count, busy
  );

  modport slave (
    input pix_valid, pix_index, pix_x, pix_y, pix_bright, pix_b, pix_g, pix_r,
    input frame_done, frame_err, frame_count, busy
  );

endinterface

// File: rtl/apa102_sync_edge.sv
// Brings the asynchronous LED clock/data into the clk domain and emits a one-cycle
// strobe per selected LED-clock edge, with the data bit aligned to that strobe.
module apa102_sync_edge #(
  parameter int SAMPLE_FALL = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic led_clk,
  input  logic led_data,
  output logic strobe,
  output logic data
);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic strobe_q, strobe_d;
  logic data_q;

  always_comb begin
    strobe_d = 1'b0;
    if (SAMPLE_FALL != 0) begin
      strobe_d = clk_prev_q & ~clk_sync_q;
    end else begin
      strobe_d = ~clk_prev_q & clk_sync_q;
    end
  end

  // Data travels through the same number of flops as the clock so the bit
  // presented with the strobe is the one that was stable at the LED edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta_q  <= 1'b0;
      clk_sync_q  <= 1'b0;
      clk_prev_q  <= 1'b0;
      data_meta_q <= 1'b0;
      data_sync_q <= 1'b0;
      strobe_q    <= 1'b0;
      data_q      <= 1'b0;
    end else begin
      clk_meta_q  <= led_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= led_data;
      data_sync_q <= data_meta_q;
      strobe_q    <= strobe_d;
      data_q      <= data_sync_q;
    end
  end

  assign strobe = strobe_q;
  assign data   = data_q;

endmodule

// File: rtl/apa102_frame_rx.sv
// APA102 stream receiver: locks onto the 32-bit zero start frame, decodes LED words
// and emits one pixel write per LED with de-serpentined matrix coordinates.
module apa102_frame_rx
  import apa102_pkg::*;
#(
  parameter int MATRIX_W     = 8,
  parameter int MATRIX_H     = 8,
  parameter int SERPENTINE   = 1,
  parameter int SAMPLE_FALL  = 0,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              led_clk,
  input  logic              led_data,
  apa102_frame_rx_if.master pix_if
);

  localparam int NUM_LEDS = MATRIX_W * MATRIX_H;
  localparam int IDX_W    = $clog2(NUM_LEDS);
  localparam int X_W      = $clog2(MATRIX_W);
  localparam int Y_W      = $clog2(MATRIX_H);
  localparam int CNT_W    = $clog2(WORD_BITS + 1);
  localparam int IDLE_W   = $clog2(IDLE_TIMEOUT + 1);

  logic strobe, sbit;

  apa102_sync_edge #(
    .SAMPLE_FALL(SAMPLE_FALL)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .led_clk (led_clk),
    .led_data(led_data),
    .strobe  (strobe),
    .data    (sbit)
  );

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] zero_run_q, zero_run_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]      shift_q, shift_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  logic             pix_valid_q, pix_valid_d;
  logic [IDX_W-1:0] pix_index_q, pix_index_d;
  logic [X_W-1:0]   pix_x_q, pix_x_d;
  logic [Y_W-1:0]   pix_y_q, pix_y_d;
  logic [4:0]       pix_bright_q, pix_bright_d;
  logic [7:0]       pix_b_q, pix_b_d;
  logic [7:0]       pix_g_q, pix_g_d;
  logic [7:0]       pix_r_q, pix_r_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       frame_count_q, frame_count_d;

  logic [31:0]      word_next;
  logic [X_W-1:0]   map_col;
  logic [X_W-1:0]   map_x;
  logic [Y_W-1:0]   map_y;

  // Even rows of a serpentine chain run right-to-left.
  always_comb begin
    map_col = X_W'(word_idx_q % IDX_W'(MATRIX_W));
    map_y   = Y_W'(word_idx_q / IDX_W'(MATRIX_W));
    map_x   = map_col;
    if ((SERPENTINE != 0) && !map_y[0]) begin
      map_x = X_W'(MATRIX_W - 1) - map_col;
    end
  end

  always_comb begin
    state_d       = state_q;
    zero_run_d    = zero_run_q;
    bit_cnt_d     = bit_cnt_q;
    word_idx_d    = word_idx_q;
    shift_d       = shift_q;
    idle_cnt_d    = idle_cnt_q;
    pix_valid_d   = 1'b0;
    pix_index_d   = pix_index_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_bright_d  = pix_bright_q;
    pix_b_d       = pix_b_q;
    pix_g_d       = pix_g_q;
    pix_r_d       = pix_r_q;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    word_next     = {shift_q[30:0], sbit};

    case (state_q)
      HUNT: begin
        idle_cnt_d = '0;
        if (strobe) begin
          if (!sbit) begin
            if (zero_run_q != CNT_W'(START_ZERO_BITS)) begin
              zero_run_d = zero_run_q + 1'b1;
            end
          end else if (zero_run_q == CNT_W'(START_ZERO_BITS)) begin
            state_d    = PIXEL;
            shift_d    = word_next;
            bit_cnt_d  = CNT_W'(1);
            word_idx_d = '0;
            zero_run_d = '0;
          end else begin
            zero_run_d = '0;
          end
        end
      end

      PIXEL: begin
        if (strobe) begin
          idle_cnt_d = '0;
          shift_d    = word_next;
          if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
            bit_cnt_d = '0;
            if (word_next[HDR_MSB:HDR_LSB] == HDR_ONES) begin
              pix_valid_d  = 1'b1;
              pix_index_d  = word_idx_q;
              pix_x_d      = map_x;
              pix_y_d      = map_y;
              pix_bright_d = word_next[BRIGHT_MSB:BRIGHT_LSB];
              pix_b_d      = word_next[B_MSB:B_LSB];
              pix_g_d      = word_next[G_MSB:G_LSB];
              pix_r_d      = word_next[R_MSB:R_LSB];
              if (word_idx_q == IDX_W'(NUM_LEDS - 1)) begin
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + 8'd1;
                state_d       = HUNT;
                zero_run_d    = '0;
                word_idx_d    = '0;
              end else begin
                word_idx_d = word_idx_q + 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
              state_d     = HUNT;
              zero_run_d  = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        // A stalled LED clock abandons the frame; the partial word is dropped.
        end else if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
          frame_err_d = 1'b1;
          state_d     = HUNT;
          zero_run_d  = '0;
          bit_cnt_d   = '0;
          idle_cnt_d  = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= HUNT;
      zero_run_q    <= '0;
      bit_cnt_q     <= '0;
      word_idx_q    <= '0;
      shift_q       <= '0;
      idle_cnt_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_index_q   <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_bright_q  <= '0;
      pix_b_q       <= '0;
      pix_g_q       <= '0;
      pix_r_q       <= '0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      zero_run_q    <= zero_run_d;
      bit_cnt_q     <= bit_cnt_d;
      word_idx_q    <= word_idx_d;
      shift_q       <= shift_d;
      idle_cnt_q    <= idle_cnt_d;
      pix_valid_q   <= pix_valid_d;
      pix_index_q   <= pix_index_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_bright_q  <= pix_bright_d;
      pix_b_q       <= pix_b_d;
      pix_g_q       <= pix_g_d;
      pix_r_q       <= pix_r_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pix_if.pix_valid   = pix_valid_q;
  assign pix_if.pix_index   = pix_index_q;
  assign pix_if.pix_x       = pix_x_q;
  assign pix_if.pix_y       = pix_y_q;
  assign pix_if.pix_bright  = pix_bright_q;
  assign pix_if.pix_b       = pix_b_q;
  assign pix_if.pix_g       = pix_g_q;
  assign pix_if.pix_r       = pix_r_q;
  assign pix_if.frame_done  = frame_done_q;
  assign pix_if.frame_err   = frame_err_q;
  assign pix_if.frame_count = frame_count_q;
  assign pix_if.busy        = (state_q == PIXEL);

endmodule
